// File: rtl/sc_io_input_port.sv
// Memory-mapped input port block: two 4-bit switch groups, each synchronised and
// debounced, with sticky change flags and a registered CPU read word.
module sc_io_input_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] ADDR_PORT0      = 32'hC0,
    parameter logic [31:0] ADDR_PORT1      = 32'hC4,
    parameter logic [31:0] ADDR_STATUS     = 32'hC8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [3:0]  in_port0,
    input  logic [3:0]  in_port1,
    input  logic [31:0] addr,
    input  logic        rd,
    output logic [31:0] io_read_data,
    output logic [1:0]  changed
);

    typedef enum logic {
        IDLE,
        COUNT
    } db_state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES);

    db_state_t  state_q  [2];
    db_state_t  state_d  [2];
    logic [3:0] sync1_q  [2];
    logic [3:0] sync2_q  [2];
    logic [3:0] cand_q   [2];
    logic [3:0] cand_d   [2];
    logic [3:0] stable_q [2];
    logic [3:0] stable_d [2];
    logic [7:0] cnt_q    [2];
    logic [7:0] cnt_d    [2];
    logic [1:0] accept;
    logic [1:0] changed_d;
    logic [31:0] rd_word;
    logic        is_status;
    logic        addr_unused_bits;

    assign addr_unused_bits = ^addr[1:0];

    // Debounce next-state: both ports share the same rules, evaluated independently.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            state_d[p[0]]  = state_q[p[0]];
            cand_d[p[0]]   = cand_q[p[0]];
            cnt_d[p[0]]    = cnt_q[p[0]];
            stable_d[p[0]] = stable_q[p[0]];
            accept[p[0]]   = 1'b0;
            case (state_q[p[0]])
                IDLE: begin
                    if (sync2_q[p[0]] != stable_q[p[0]]) begin
                        cand_d[p[0]] = sync2_q[p[0]];
                        if (DEBOUNCE_CYCLES == 1) begin
                            stable_d[p[0]] = sync2_q[p[0]];
                            accept[p[0]]   = 1'b1;
                            cnt_d[p[0]]    = '0;
                        end else begin
                            cnt_d[p[0]]   = 8'd1;
                            state_d[p[0]] = COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (sync2_q[p[0]] == stable_q[p[0]]) begin
                        cnt_d[p[0]]   = '0;
                        state_d[p[0]] = IDLE;
                    end else if (sync2_q[p[0]] != cand_q[p[0]]) begin
                        cand_d[p[0]] = sync2_q[p[0]];
                        cnt_d[p[0]]  = 8'd1;
                    end else if ((cnt_q[p[0]] + 8'd1) == CNT_LAST) begin
                        stable_d[p[0]] = cand_q[p[0]];
                        accept[p[0]]   = 1'b1;
                        cnt_d[p[0]]    = '0;
                        state_d[p[0]]  = IDLE;
                    end else begin
                        cnt_d[p[0]] = cnt_q[p[0]] + 8'd1;
                    end
                end
                default: begin
                    cnt_d[p[0]]   = '0;
                    state_d[p[0]] = IDLE;
                end
            endcase
        end
    end

    // Read word uses pre-edge state; an accept on the clearing edge still sets its flag.
    always_comb begin
        rd_word   = '0;
        is_status = (addr[31:2] == ADDR_STATUS[31:2]);
        if (addr[31:2] == ADDR_PORT0[31:2]) begin
            rd_word = {28'b0, stable_q[0]};
        end else if (addr[31:2] == ADDR_PORT1[31:2]) begin
            rd_word = {28'b0, stable_q[1]};
        end else if (is_status) begin
            rd_word = {30'b0, changed};
        end
        changed_d = (rd && is_status) ? accept : (changed | accept);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned p = 0; p < 2; p++) begin
                sync1_q[p[0]]  <= '0;
                sync2_q[p[0]]  <= '0;
                cand_q[p[0]]   <= '0;
                cnt_q[p[0]]    <= '0;
                stable_q[p[0]] <= '0;
                state_q[p[0]]  <= IDLE;
            end
            changed      <= '0;
            io_read_data <= '0;
        end else begin
            sync1_q[0] <= in_port0;
            sync1_q[1] <= in_port1;
            for (int unsigned p = 0; p < 2; p++) begin
                sync2_q[p[0]]  <= sync1_q[p[0]];
                cand_q[p[0]]   <= cand_d[p[0]];
                cnt_q[p[0]]    <= cnt_d[p[0]];
                stable_q[p[0]] <= stable_d[p[0]];
                state_q[p[0]]  <= state_d[p[0]];
            end
            changed <= changed_d;
            if (rd) begin
                io_read_data <= rd_word;
            end
        end
    end

endmodule
